// File: rtl/jump_control_unit.sv
// Hardwired fetch / control-transfer sequencer (jr, jal, br, nop, halt) for the Datapath.
// Optional macro JCU_BRANCH_EN enables the br sequence; when undefined, br decodes as nop.
module jump_control_unit #(
   parameter logic [4:0] OP_ADD   = 5'b00011,
   parameter logic [3:0] LINK_REG = 4'd15
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        mem_rdy,
   output logic        PC_out,
   output logic        MDR_out,
   output logic        Zlo_out,
   output logic        R_out,
   output logic        C_out,
   output logic        MARin,
   output logic        MDRin,
   output logic        IRin,
   output logic        PCin,
   output logic        Yin,
   output logic        Zlowin,
   output logic        Rin,
   output logic        CONin,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        BAout,
   output logic        link_sel,
   output logic [3:0]  link_idx,
   output logic [4:0]  op_sel,
   output logic        Run,
   output logic [3:0]  state_view
);

   typedef enum logic [3:0] {
      S_RST  = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_HALT = 4'd8
   } state_t;

   localparam logic [4:0] OPC_BR   = 5'b10010;
   localparam logic [4:0] OPC_JR   = 5'b10011;
   localparam logic [4:0] OPC_JAL  = 5'b10100;
   localparam logic [4:0] OPC_HALT = 5'b11010;

   state_t      state_reg;
   state_t      state_next;
   logic [4:0]  opcode;
   logic        is_br;
   logic        unused_ir;

   assign opcode    = IR[31:27];
   assign unused_ir = &{1'b0, IR[26:0]};

`ifdef JCU_BRANCH_EN
   assign is_br = (opcode == OPC_BR);
`else
   assign is_br = 1'b0;
`endif

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state_reg <= S_RST;
      else      state_reg <= state_next;
   end

   // These strobes are never used by this instruction group.
   assign Write      = 1'b0;
   assign Grb        = 1'b0;
   assign Grc        = 1'b0;
   assign BAout      = 1'b0;
   assign link_idx   = LINK_REG;
   assign state_view = state_reg;

   // Strobes decode from the state register; IR matters only in T3/T4, CON_FF only in T6.
   always_comb begin
      state_next = state_reg;
      PC_out   = 1'b0;
      MDR_out  = 1'b0;
      Zlo_out  = 1'b0;
      R_out    = 1'b0;
      C_out    = 1'b0;
      MARin    = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      PCin     = 1'b0;
      Yin      = 1'b0;
      Zlowin   = 1'b0;
      Rin      = 1'b0;
      CONin    = 1'b0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      Gra      = 1'b0;
      link_sel = 1'b0;
      op_sel   = 5'd0;
      Run      = 1'b0;
      case (state_reg)
         S_RST: state_next = S_T0;
         S_T0: begin
            Run = 1'b1; PC_out = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
            state_next = S_T1;
         end
         S_T1: begin
            // Read/MDRin stay up for every wait state until memory answers.
            Run = 1'b1; Zlo_out = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            if (mem_rdy) state_next = S_T2;
         end
         S_T2: begin
            Run = 1'b1; MDR_out = 1'b1; IRin = 1'b1;
            state_next = S_T3;
         end
         S_T3: begin
            Run = 1'b1;
            state_next = S_T0;
            if (opcode == OPC_JR) begin
               Gra = 1'b1; R_out = 1'b1; PCin = 1'b1;
            end else if (opcode == OPC_JAL) begin
               PC_out = 1'b1; Rin = 1'b1; link_sel = 1'b1;
               state_next = S_T4;
            end else if (is_br) begin
               Gra = 1'b1; R_out = 1'b1; CONin = 1'b1;
               state_next = S_T4;
            end else if (opcode == OPC_HALT) begin
               state_next = S_HALT;
            end
         end
         S_T4: begin
            Run = 1'b1;
            state_next = S_T0;
            if (opcode == OPC_JAL) begin
               Gra = 1'b1; R_out = 1'b1; PCin = 1'b1;
            end else if (is_br) begin
               PC_out = 1'b1; Yin = 1'b1;
               state_next = S_T5;
            end
         end
         S_T5: begin
            Run = 1'b1; C_out = 1'b1; Zlowin = 1'b1; op_sel = OP_ADD;
            state_next = S_T6;
         end
         S_T6: begin
            Run = 1'b1; Zlo_out = 1'b1; PCin = CON_FF;
            state_next = S_T0;
         end
         S_HALT: state_next = S_HALT;
         default: state_next = S_RST;
      endcase
   end

endmodule
